// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with LRU and invalidate sweep.
// Optional BTB_STATS_EN adds lookup/hit counters and the Stat_* ports.
module branch_target_buffer #(
    parameter int SETS = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic [31:0] IF_PC,
    output logic        Hit_BTB,
    output logic [31:0] Alt_PC_BTB,
    input  logic [31:0] ID_PC,
    input  logic [31:0] Alt_PC_ID,
    input  logic        Is_Branch,
    input  logic        Is_Taken,
    input  logic        Inval,
    output logic        Inval_Busy
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] Stat_Lookups,
    output logic [31:0] Stat_Hits
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [SETS-1:0][1:0]       valid_q, valid_d;
    logic [SETS-1:0]            lru_q, lru_d;
    logic [TAG_W-1:0]           tag_q [SETS][2];
    logic [31:0]                tgt_q [SETS][2];

    logic [IDX_W-1:0]           if_idx, id_idx;
    logic [TAG_W-1:0]           if_tag, id_tag;
    logic                       busy;
    logic                       hit0, hit1, hit_way;
    logic                       m0, m1, upd_en, upd_way;
    logic                       unused_pc_bits;

    assign if_idx         = IF_PC[IDX_W+1:2];
    assign if_tag         = IF_PC[31:IDX_W+2];
    assign id_idx         = ID_PC[IDX_W+1:2];
    assign id_tag         = ID_PC[31:IDX_W+2];
    assign busy           = (state_q == SWEEP);
    assign Inval_Busy     = busy;
    assign unused_pc_bits = ^{IF_PC[1:0], ID_PC[1:0]};

    // Fetch lookup: way0 wins when both ways match; sweep suppresses hits
    always_comb begin
        hit0       = valid_q[if_idx][0] && (tag_q[if_idx][0] == if_tag) && !busy;
        hit1       = valid_q[if_idx][1] && (tag_q[if_idx][1] == if_tag) && !busy;
        hit_way    = !hit0;
        Hit_BTB    = hit0 || hit1;
        Alt_PC_BTB = 32'd0;
        if (hit0)      Alt_PC_BTB = tgt_q[if_idx][0];
        else if (hit1) Alt_PC_BTB = tgt_q[if_idx][1];
    end

    // Decode update: refresh a matching way, else fill invalid way or LRU victim
    always_comb begin
        m0     = valid_q[id_idx][0] && (tag_q[id_idx][0] == id_tag);
        m1     = valid_q[id_idx][1] && (tag_q[id_idx][1] == id_tag);
        upd_en = Is_Branch && Is_Taken && !STALL && !busy;
        if (m0)                       upd_way = 1'b0;
        else if (m1)                  upd_way = 1'b1;
        else if (!valid_q[id_idx][0]) upd_way = 1'b0;
        else if (!valid_q[id_idx][1]) upd_way = 1'b1;
        else                          upd_way = lru_q[id_idx];
    end

    // Valid/LRU next state; update's LRU write overrides the fetch touch
    always_comb begin
        valid_d = valid_q;
        lru_d   = lru_q;
        if (Hit_BTB && !STALL) lru_d[if_idx] = ~hit_way;
        if (upd_en) begin
            valid_d[id_idx][upd_way] = 1'b1;
            lru_d[id_idx]            = ~upd_way;
        end
        if (busy) begin
            valid_d[ptr_q] = 2'b00;
            lru_d[ptr_q]   = 1'b0;
        end
    end

    // Invalidate sequencer: one set per cycle, Inval restarts from set 0
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (Inval) begin
            state_d = SWEEP;
            ptr_d   = '0;
        end else if (busy) begin
            if (ptr_q == IDX_W'(SETS - 1)) begin
                state_d = IDLE;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end
    end

    // Control state and valid/LRU bits
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
    end

    // Tag/target storage, gated by valid so it needs no reset
    always_ff @(posedge CLK) begin
        if (upd_en) begin
            tag_q[id_idx][upd_way] <= id_tag;
            tgt_q[id_idx][upd_way] <= Alt_PC_ID;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] hits_q, hits_d;

    assign Stat_Lookups = lookups_q;
    assign Stat_Hits    = hits_q;

    // Count unstalled lookups outside a sweep, and the hits among them
    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        if (!STALL && !busy) begin
            lookups_d = lookups_q + 32'd1;
            if (Hit_BTB) hits_d = hits_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (SETS=64).
// Expected lookup results are queued at drive time and popped at sample time.
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic [31:0] IF_PC = '0;
    logic        Hit_BTB;
    logic [31:0] Alt_PC_BTB;
    logic [31:0] ID_PC = '0;
    logic [31:0] Alt_PC_ID = '0;
    logic        Is_Branch = 1'b0;
    logic        Is_Taken = 1'b0;
    logic        Inval = 1'b0;
    logic        Inval_Busy;
`ifdef BTB_STATS_EN
    logic [31:0] Stat_Lookups;
    logic [31:0] Stat_Hits;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hit;
        logic [31:0] alt;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];

    branch_target_buffer #(.SETS(64)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .STALL(STALL),
        .IF_PC(IF_PC),
        .Hit_BTB(Hit_BTB),
        .Alt_PC_BTB(Alt_PC_BTB),
        .ID_PC(ID_PC),
        .Alt_PC_ID(Alt_PC_ID),
        .Is_Branch(Is_Branch),
        .Is_Taken(Is_Taken),
        .Inval(Inval),
        .Inval_Busy(Inval_Busy)
`ifdef BTB_STATS_EN
        ,
        .Stat_Lookups(Stat_Lookups),
        .Stat_Hits(Stat_Hits)
`endif
    );

    always #5 CLK = ~CLK;

    // One clock cycle: drive at negedge, optionally queue an expectation,
    // then sample the combinational lookup 2ns later and score it.
    task automatic cyc(input logic [31:0] ifpc, input logic br,
                       input logic tk, input logic [31:0] idpc,
                       input logic [31:0] tgt, input logic st,
                       input logic inv, input bit chk, input logic eh,
                       input logic [31:0] ea, input string nm);
        exp_t  e;
        string n;
        @(negedge CLK);
        IF_PC     = ifpc;
        Is_Branch = br;
        Is_Taken  = tk;
        ID_PC     = idpc;
        Alt_PC_ID = tgt;
        STALL     = st;
        Inval     = inv;
        if (chk) begin
            exp_q.push_back('{hit: eh, alt: ea});
            name_q.push_back(nm);
        end
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (Hit_BTB !== e.hit || Alt_PC_BTB !== e.alt) begin
                errors++;
                $display("FAIL %s: hit=%0b alt=%h, expected hit=%0b alt=%h",
                         n, Hit_BTB, Alt_PC_BTB, e.hit, e.alt);
            end
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic eh,
                          input logic [31:0] ea, input string nm);
        cyc(pc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, eh, ea, nm);
    endtask

    task automatic branch(input logic [31:0] idpc, input logic [31:0] tgt,
                          input logic tk);
        cyc(32'h00500000, 1'b1, tk, idpc, tgt, 1'b0, 1'b0, 1'b0, 1'b0,
            32'h0, "");
    endtask

    task automatic idle();
        cyc(32'h00500000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
            1'b0, 32'h0, "");
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET     = 1'b0;
        STALL     = 1'b1;
        Is_Branch = 1'b0;
        Is_Taken  = 1'b0;
        Inval     = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        checks++;
        if (Inval_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b, expected 0", Inval_Busy);
        end
        lookup(32'h00400010, 1'b0, 32'h0, "reset_lookup");
    endtask

    task automatic test_alloc();
        cyc(32'h00400010, 1'b1, 1'b1, 32'h00400010, 32'h00400100, 1'b0,
            1'b0, 1'b1, 1'b0, 32'h0, "no_bypass");
        lookup(32'h00400010, 1'b1, 32'h00400100, "alloc_hit");
        lookup(32'h00400013, 1'b1, 32'h00400100, "low_bits_ignored");
    endtask

    task automatic test_not_taken();
        branch(32'h00400020, 32'h00400400, 1'b0);
        lookup(32'h00400020, 1'b0, 32'h0, "not_taken_miss");
        lookup(32'h00400010, 1'b1, 32'h00400100, "not_taken_keep");
    endtask

    task automatic test_stall();
        cyc(32'h00500000, 1'b1, 1'b1, 32'h00400040, 32'h00400440, 1'b1,
            1'b0, 1'b0, 1'b0, 32'h0, "");
        lookup(32'h00400040, 1'b0, 32'h0, "stalled_update_dropped");
    endtask

    task automatic test_lru();
        branch(32'h00400110, 32'h00400200, 1'b1);
        lookup(32'h00400110, 1'b1, 32'h00400200, "fill_way1");
        lookup(32'h00400010, 1'b1, 32'h00400100, "touch_way0");
        branch(32'h00400210, 32'h00400300, 1'b1);
        lookup(32'h00400110, 1'b0, 32'h0, "lru_evicted");
        lookup(32'h00400010, 1'b1, 32'h00400100, "lru_keep_way0");
        lookup(32'h00400210, 1'b1, 32'h00400300, "lru_new_entry");
        branch(32'h00400010, 32'h00400180, 1'b1);
        lookup(32'h00400010, 1'b1, 32'h00400180, "refresh_target");
        lookup(32'h00400210, 1'b1, 32'h00400300, "refresh_no_evict");
    endtask

    task automatic test_back_to_back();
        branch(32'h00400030, 32'h00400a00, 1'b1);
        branch(32'h00400034, 32'h00400b00, 1'b1);
        lookup(32'h00400030, 1'b1, 32'h00400a00, "b2b_first");
        lookup(32'h00400034, 1'b1, 32'h00400b00, "b2b_second");
    endtask

    // Counts busy cycles after the pulse; restart_at>=0 re-pulses Inval
    task automatic sweep(input int restart_at, input int exp_len,
                         input string nm);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        cyc(32'h00400010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
            1'b0, 32'h0, "");
        for (int i = 0; i < 300 && !done; i++) begin
            cyc(32'h00400010, (i == 0), (i == 0), 32'h00400050,
                32'h00400550, (i == 2), (i == restart_at), 1'b1, 1'b0,
                32'h0, "sweep_no_hit");
            if (Inval_Busy === 1'b1) n++;
            else done = 1'b1;
        end
        checks++;
        if (!done || n != exp_len) begin
            errors++;
            $display("FAIL %s: busy cycles=%0d, expected %0d", nm, n,
                     exp_len);
        end
    endtask

    task automatic test_inval();
        sweep(-1, 64, "inval_length");
        lookup(32'h00400010, 1'b0, 32'h0, "inval_cleared_a");
        lookup(32'h00400210, 1'b0, 32'h0, "inval_cleared_b");
        lookup(32'h00400050, 1'b0, 32'h0, "inval_update_dropped");
        branch(32'h00400010, 32'h00400700, 1'b1);
        lookup(32'h00400010, 1'b1, 32'h00400700, "post_inval_alloc");
        sweep(10, 75, "inval_restart");
        lookup(32'h00400010, 1'b0, 32'h0, "restart_cleared");
    endtask

    task automatic test_reset_mid_sweep();
        branch(32'h00400010, 32'h00400800, 1'b1);
        cyc(32'h00500000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
            1'b0, 32'h0, "");
        repeat (3) idle();
        apply_reset();
        #2;
        checks++;
        if (Inval_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%0b, expected 0", Inval_Busy);
        end
        lookup(32'h00400010, 1'b0, 32'h0, "reset_invalidates");
    endtask

`ifdef BTB_STATS_EN
    task automatic test_stats();
        apply_reset();
        branch(32'h00400010, 32'h00400100, 1'b1);
        repeat (3) lookup(32'h00400010, 1'b1, 32'h00400100, "stat_hit");
        repeat (2) cyc(32'h00400010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0,
                       1'b1, 1'b1, 32'h00400100, "stat_stalled");
        repeat (6) lookup(32'h00400060, 1'b0, 32'h0, "stat_miss");
        cyc(32'h00400010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0,
            1'b0, 32'h0, "");
        checks++;
        if (Stat_Lookups !== 32'd10 || Stat_Hits !== 32'd3) begin
            errors++;
            $display("FAIL stats: lookups=%0d hits=%0d, expected 10 and 3",
                     Stat_Lookups, Stat_Hits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alloc();
        test_not_taken();
        test_stall();
        test_lru();
        test_back_to_back();
        test_inval();
        test_reset_mid_sweep();
`ifdef BTB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
